// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sampling controller.
// The configuration word layout matches the ADC's 6-bit serial config register.
package adc_pkg;

  localparam int unsigned FRAME_BITS   = 12;
  localparam int unsigned CFG_BITS     = 6;
  localparam int unsigned START_CYCLES = 2;

  localparam logic SD_SINGLE    = 1'b1;
  localparam logic UNI_UNIPOLAR = 1'b1;
  localparam logic SLP_NAP      = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CONV,
    SHIFT,
    DONE
  } adc_state_e;

  // Full 12-bit din stream: config bits first, zero padding for the rest.
  function automatic logic [FRAME_BITS-1:0] cfg_word(input logic [2:0] ch);
    return {SD_SINGLE, ch[0], ch[2], ch[1], UNI_UNIPOLAR, SLP_NAP,
            {(FRAME_BITS - CFG_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// ADC serial pin bundle; master is the controller, slave is the converter.
interface adc_sample_ctrl_if;

  logic adc_convst;
  logic adc_sclk;
  logic adc_din;
  logic adc_dout;

  modport master (
    output adc_convst,
    output adc_sclk,
    output adc_din,
    input  adc_dout
  );

  modport slave (
    input  adc_convst,
    input  adc_sclk,
    input  adc_din,
    output adc_dout
  );

endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider and bit counter for the SHIFT phase; low half first, idle low.
// Strobes mark the clk edge on which SCLK rises or falls.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb,
  output logic last_bit
);

  logic [7:0] div_q, div_d;
  logic       sclk_q, sclk_d;
  logic [3:0] bit_q, bit_d;
  logic       half_end;

  always_comb begin
    half_end = en && (div_q == 8'(SCLK_DIV - 1));
    rise_stb = half_end && !sclk_q;
    fall_stb = half_end && sclk_q;
    last_bit = (bit_q == 4'(FRAME_BITS - 1));

    div_d  = div_q;
    sclk_d = sclk_q;
    bit_d  = bit_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b0;
      bit_d  = '0;
    end else if (half_end) begin
      div_d  = '0;
      sclk_d = !sclk_q;
      if (sclk_q) begin
        bit_d = last_bit ? '0 : bit_q + 4'd1;
      end
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      bit_q  <= bit_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Frame sequencer for a serial SAR ADC: CONVST pulse, conversion wait,
// 12-bit full-duplex shift, then publish the result with its channel tag.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_DIV    = 2,
  parameter int unsigned CONV_CYCLES = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [2:0]            ch_sel,
  adc_sample_ctrl_if.master     adc,
  output logic [FRAME_BITS-1:0] sample,
  output logic [2:0]            sample_ch,
  output logic                  sample_valid
);

  adc_state_e            state_q, state_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [2:0]            ch_lat_q, ch_lat_d;
  logic [2:0]            prev_ch_q, prev_ch_d;
  logic                  first_q, first_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic                  din_q, din_d;
  logic                  convst_q, convst_d;
  logic [FRAME_BITS-1:0] sample_q, sample_d;
  logic [2:0]            sample_ch_q, sample_ch_d;
  logic                  valid_q, valid_d;

  logic                  shift_en;
  logic                  sclk_w;
  logic                  rise_stb;
  logic                  fall_stb;
  logic                  last_bit;
  logic [FRAME_BITS-1:0] cfg;

  assign shift_en = (state_q == SHIFT);

  adc_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (shift_en),
    .sclk     (sclk_w),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .last_bit (last_bit)
  );

  always_comb begin
    cfg         = cfg_word(ch_lat_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_lat_d    = ch_lat_q;
    prev_ch_d   = prev_ch_q;
    first_d     = first_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    din_d       = din_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;

    unique case (state_q)
      IDLE: begin
        first_d = 1'b1;
        din_d   = 1'b0;
        if (run) begin
          state_d  = START;
          cnt_d    = '0;
          ch_lat_d = ch_sel;
        end
      end
      START: begin
        if (cnt_q == 10'(START_CYCLES - 1)) begin
          state_d = CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      CONV: begin
        if (cnt_q == 10'(CONV_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          // First din bit is presented on the implicit falling edge at frame start.
          din_d   = cfg[FRAME_BITS-1];
          tx_d    = {cfg[FRAME_BITS-2:0], 1'b0};
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      SHIFT: begin
        if (rise_stb) begin
          rx_d = {rx_q[FRAME_BITS-2:0], adc.adc_dout};
        end
        if (fall_stb) begin
          if (last_bit) begin
            state_d  = DONE;
            din_d    = 1'b0;
            sample_d = rx_q;
            // The result belongs to the config sent one frame earlier,
            // except when the ADC's prior config is unknown.
            sample_ch_d = first_q ? ch_lat_q : prev_ch_q;
          end else begin
            din_d = tx_q[FRAME_BITS-1];
            tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        prev_ch_d = ch_lat_q;
        first_d   = 1'b0;
        if (run) begin
          state_d  = START;
          cnt_d    = '0;
          ch_lat_d = ch_sel;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    convst_d = (state_d == START);
    valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_lat_q    <= '0;
      prev_ch_q   <= '0;
      first_q     <= 1'b1;
      rx_q        <= '0;
      tx_q        <= '0;
      din_q       <= 1'b0;
      convst_q    <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_lat_q    <= ch_lat_d;
      prev_ch_q   <= prev_ch_d;
      first_q     <= first_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      din_q       <= din_d;
      convst_q    <= convst_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      valid_q     <= valid_d;
    end
  end

  assign adc.adc_convst = convst_q;
  assign adc.adc_sclk   = sclk_w;
  assign adc.adc_din    = din_q;
  assign sample         = sample_q;
  assign sample_ch      = sample_ch_q;
  assign sample_valid   = valid_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl: default-timing instance plus a fast
// instance (SCLK_DIV=1, CONV_CYCLES=1), each driven by a small ADC model.
module tb_adc_sample_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, run_a, sv_a;
  logic [2:0]  ch_a, samch_a;
  logic [11:0] sample_a;
  logic        reset_b, run_b, sv_b;
  logic [2:0]  ch_b, samch_b;
  logic [11:0] sample_b;

  adc_sample_ctrl_if ifa ();
  adc_sample_ctrl_if ifb ();

  adc_sample_ctrl dut_a (
    .clk          (clk),
    .reset        (reset_a),
    .run          (run_a),
    .ch_sel       (ch_a),
    .adc          (ifa),
    .sample       (sample_a),
    .sample_ch    (samch_a),
    .sample_valid (sv_a)
  );

  adc_sample_ctrl #(
    .SCLK_DIV    (1),
    .CONV_CYCLES (1)
  ) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .run          (run_b),
    .ch_sel       (ch_b),
    .adc          (ifb),
    .sample       (sample_b),
    .sample_ch    (samch_b),
    .sample_valid (sv_b)
  );

  // ADC models: present the next result bit after every SCLK fall.
  logic [11:0] word_a, word_b;
  int unsigned bidx_a = 12, bidx_b = 12;
  always @(posedge ifa.adc_convst) bidx_a = 0;
  always @(negedge ifa.adc_sclk)   bidx_a = bidx_a + 1;
  always @(posedge ifb.adc_convst) bidx_b = 0;
  always @(negedge ifb.adc_sclk)   bidx_b = bidx_b + 1;
  always_comb ifa.adc_dout = (bidx_a < 12) ? word_a[4'(11 - bidx_a)] : 1'b0;
  always_comb ifb.adc_dout = (bidx_b < 12) ? word_b[4'(11 - bidx_b)] : 1'b0;

  logic [11:0] cap_a = '0;
  int          rise_a = 0;
  always @(posedge ifa.adc_convst) rise_a = 0;
  always @(posedge ifa.adc_sclk) begin
    cap_a  = {cap_a[10:0], ifa.adc_din};
    rise_a = rise_a + 1;
  end

  int   cyc = 0;
  int   s_a = 0, v_a = 0, n_start_a = 0, n_valid_a = 0, hi_a = 0;
  int   s_b = 0, v_b = 0, n_valid_b = 0;
  logic conv_prev_a = 1'b0, conv_prev_b = 1'b0;
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (ifa.adc_convst && !conv_prev_a) begin
      n_start_a = n_start_a + 1;
      s_a  = cyc;
      hi_a = 0;
    end
    if (ifa.adc_convst) hi_a = hi_a + 1;
    conv_prev_a = ifa.adc_convst;
    if (sv_a) begin
      n_valid_a = n_valid_a + 1;
      v_a = cyc;
    end
    if (ifb.adc_convst && !conv_prev_b) s_b = cyc;
    conv_prev_b = ifb.adc_convst;
    if (sv_b) begin
      n_valid_b = n_valid_b + 1;
      v_b = cyc;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cond(input int which, input int arg);
    case (which)
      0:       return n_start_a >= arg;
      1:       return n_valid_a >= arg;
      2:       return rise_a >= arg;
      default: return n_valid_b >= arg;
    endcase
  endfunction

  task automatic wait_for(input int which, input int arg, input string tag);
    int k = 0;
    while (!cond(which, arg) && k < 2000) begin
      @(negedge clk);
      k = k + 1;
    end
    if (!cond(which, arg)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({ifa.adc_convst, ifa.adc_sclk, ifa.adc_din, sample_a, samch_a, sv_a});
  endfunction

  initial begin
    int ns, nv, s1, v1;
    reset_a = 1'b1; reset_b = 1'b1;
    run_a = 1'b0;   run_b = 1'b0;
    ch_a = 3'd0;    ch_b = 3'd0;
    word_a = '0;    word_b = '0;
    repeat (3) @(negedge clk);

    check("rst_outs_a", outs_a(), 32'd0);
    check("rst_pins_b", 32'({ifb.adc_convst, ifb.adc_sclk, ifb.adc_din, sv_b}), 32'd0);

    // First frame from reset, channel 0, result 0xA5C
    word_a = 12'hA5C; run_a = 1'b1; reset_a = 1'b0; reset_b = 1'b0;
    ns = n_start_a; nv = n_valid_a;
    wait_for(1, nv + 1, "t1_valid");
    check("t1_sample", 32'(sample_a), 32'h0000_0A5C);
    check("t1_ch", 32'(samch_a), 32'd0);
    check("t1_len", 32'(v_a - s_a + 1), 32'd131);
    check("t1_convst_hi", 32'(hi_a), 32'd2);
    check("t1_sclk_cnt", 32'(rise_a), 32'd12);
    run_a = 1'b0;
    repeat (5) @(negedge clk);
    check("t1_one_start", 32'(n_start_a - ns), 32'd1);

    // Channel 5 then 2; ch_sel change right after START entry must not leak
    ns = n_start_a; nv = n_valid_a;
    ch_a = 3'd5; run_a = 1'b1; word_a = 12'h123;
    wait_for(0, ns + 1, "t2_start");
    ch_a = 3'd2;
    wait_for(1, nv + 1, "t2_valid1");
    check("t2_cfg1", 32'(cap_a), 32'h0000_0E80);
    check("t2_sample1", 32'(sample_a), 32'h0000_0123);
    check("t2_ch1", 32'(samch_a), 32'd5);
    word_a = 12'h9BD; s1 = s_a;
    wait_for(1, nv + 2, "t2_valid2");
    check("t2_cfg2", 32'(cap_a), 32'h0000_0980);
    check("t2_sample2", 32'(sample_a), 32'h0000_09BD);
    check("t2_ch2", 32'(samch_a), 32'd5);
    check("t2_period", 32'(s_a - s1), 32'd131);
    run_a = 1'b0;
    repeat (5) @(negedge clk);

    // One-cycle run pulse yields exactly one frame
    ns = n_start_a; nv = n_valid_a; word_a = 12'h777;
    run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0;
    repeat (300) @(negedge clk);
    check("t3_valid_cnt", 32'(n_valid_a - nv), 32'd1);
    check("t3_start_cnt", 32'(n_start_a - ns), 32'd1);
    check("t3_sample", 32'(sample_a), 32'h0000_0777);
    check("t3_idle_pins", 32'({ifa.adc_convst, ifa.adc_sclk, ifa.adc_din}), 32'd0);

    // run dropped during SHIFT bit 6: frame completes, no restart
    ns = n_start_a; nv = n_valid_a; word_a = 12'h3C6;
    run_a = 1'b1;
    wait_for(0, ns + 1, "t4_start");
    wait_for(2, 6, "t4_bit6");
    run_a = 1'b0;
    wait_for(1, nv + 1, "t4_valid");
    check("t4_sample", 32'(sample_a), 32'h0000_03C6);
    repeat (200) @(negedge clk);
    check("t4_no_restart", 32'(n_start_a - ns), 32'd1);
    check("t4_hold_sample", 32'(sample_a), 32'h0000_03C6);
    check("t4_valid_low", 32'(sv_a), 32'd0);

    // Reset during CONV
    ns = n_start_a; nv = n_valid_a; ch_a = 3'd6;
    run_a = 1'b1;
    wait_for(0, ns + 1, "t5_start");
    repeat (10) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check("t5_conv_rst", outs_a(), 32'd0);
    run_a = 1'b0; reset_a = 1'b0;
    repeat (200) @(negedge clk);
    check("t5_no_valid", 32'(n_valid_a - nv), 32'd0);

    // Reset during SHIFT bit 8, then first frame after release uses its own channel
    ns = n_start_a;
    run_a = 1'b1;
    wait_for(0, ns + 1, "t6_start");
    wait_for(2, 8, "t6_bit8");
    reset_a = 1'b1;
    @(negedge clk);
    check("t6_shift_rst", outs_a(), 32'd0);
    check("t6_no_valid", 32'(n_valid_a - nv), 32'd0);
    ch_a = 3'd3; word_a = 12'h5A1; reset_a = 1'b0;
    wait_for(1, nv + 1, "t6_valid");
    check("t6_sample", 32'(sample_a), 32'h0000_05A1);
    check("t6_ch", 32'(samch_a), 32'd3);
    run_a = 1'b0;

    // Fast instance: back-to-back frames of 2+1+24+1 cycles
    nv = n_valid_b; word_b = 12'hFFF; run_b = 1'b1;
    wait_for(3, nv + 1, "t7_valid1");
    check("t7_sample1", 32'(sample_b), 32'h0000_0FFF);
    check("t7_len", 32'(v_b - s_b + 1), 32'd28);
    check("t7_ch1", 32'(samch_b), 32'd0);
    word_b = 12'h000; s1 = s_b; v1 = v_b;
    wait_for(3, nv + 2, "t7_valid2");
    check("t7_sample2", 32'(sample_b), 32'h0000_0000);
    check("t7_start_gap", 32'(s_b - s1), 32'd28);
    check("t7_valid_gap", 32'(v_b - v1), 32'd28);
    run_b = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
